// File: rtl/arch_pkg.sv
// Shared types and Y86 status constants for the run controller and trace capture.
package arch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } run_state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE  = 3'd0,
    CAUSE_HALT  = 3'd1,
    CAUSE_FAULT = 3'd2,
    CAUSE_LIMIT = 3'd3,
    CAUSE_STOP  = 3'd4
  } done_cause_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Halt outranks any other bad status; a core-reported problem outranks limit and stop.
  function automatic done_cause_t term_cause(input logic [2:0] stat, input logic limit_hit);
    done_cause_t c;
    if (stat == STAT_HLT) begin
      c = CAUSE_HALT;
    end else if (stat != STAT_AOK) begin
      c = CAUSE_FAULT;
    end else if (limit_hit) begin
      c = CAUSE_LIMIT;
    end else begin
      c = CAUSE_STOP;
    end
    return c;
  endfunction

endpackage

// File: rtl/trace_buf.sv
// Circular (PC, value) trace RAM with saturating fill count and a registered
// newest-relative read port.
module trace_buf #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_pc,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [IDX_W:0]    count,
  output logic [ADDR_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_data
);

  localparam int CNT_W = IDX_W + 1;

  logic [ADDR_W-1:0] pc_mem_r   [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [IDX_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [ADDR_W-1:0] rd_pc_r;
  logic [DATA_W-1:0] rd_data_r;
  logic [IDX_W-1:0]  rd_addr_s;

  // Newest entry sits one behind the write pointer; power-of-two depth makes the wrap free.
  assign rd_addr_s = wr_ptr_r - IDX_W'(1) - rd_idx;

  // Storage array: written only, never reset, so contents survive a restart.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem_r[wr_ptr_r]   <= wr_pc;
      data_mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer, fill count and read register; read sees pre-write contents and old pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r  <= '0;
      count_r   <= '0;
      rd_pc_r   <= '0;
      rd_data_r <= '0;
    end else begin
      rd_pc_r   <= pc_mem_r[rd_addr_s];
      rd_data_r <= data_mem_r[rd_addr_s];
      if (clr) begin
        wr_ptr_r <= '0;
        count_r  <= '0;
      end else if (wr_en) begin
        wr_ptr_r <= wr_ptr_r + IDX_W'(1);
        if (count_r != CNT_W'(DEPTH)) begin
          count_r <= count_r + CNT_W'(1);
        end
      end
    end
  end

  assign count   = count_r;
  assign rd_pc   = rd_pc_r;
  assign rd_data = rd_data_r;

endmodule

// File: rtl/arch_run_ctrl.sv
// Run controller for the Y86-64 core: gates the core enable in free-run or
// single-step mode, counts enabled cycles, and stops on halt/fault/limit/stop.
module arch_run_ctrl
  import arch_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int CYC_W       = 32,
  parameter int TRACE_DEPTH = 16,
  parameter int IDX_W       = $clog2(TRACE_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step_req,
  input  logic              stop,
  input  logic [CYC_W-1:0]  max_cycles,
  input  logic [2:0]        core_stat,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] watch_in,
  output logic              core_en,
  output logic [1:0]        state,
  output logic [CYC_W-1:0]  cycle_count,
  output logic [2:0]        done_cause,
  output logic [IDX_W:0]    trace_count,
  input  logic [IDX_W-1:0]  trace_rd_idx,
  output logic [ADDR_W-1:0] trace_rd_pc,
  output logic [DATA_W-1:0] trace_rd_data
);

  run_state_t  state_r;
  done_cause_t cause_r;
  logic [CYC_W-1:0] cycle_r;
  logic [CYC_W-1:0] max_r;
  logic limit_hit_s;
  logic term_s;
  logic core_en_s;
  logic launch_s;

  assign limit_hit_s = (max_r != '0) && (cycle_r == max_r);
  assign term_s      = (core_stat != STAT_AOK) || stop || limit_hit_s;
  assign launch_s    = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

  // Core enable: a terminating cycle is never enabled, and reset holds the core off.
  always_comb begin
    core_en_s = 1'b0;
    if (!rst_n || term_s) begin
      core_en_s = 1'b0;
    end else if (state_r == ST_RUN) begin
      core_en_s = 1'b1;
    end else if (state_r == ST_PAUSE) begin
      core_en_s = step_req;
    end else begin
      core_en_s = 1'b0;
    end
  end

  // Run FSM with cycle counter, latched limit and termination cause.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cause_r <= CAUSE_NONE;
      cycle_r <= '0;
      max_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            cycle_r <= '0;
            cause_r <= CAUSE_NONE;
            max_r   <= max_cycles;
            state_r <= step_mode ? ST_PAUSE : ST_RUN;
          end
        end
        ST_RUN, ST_PAUSE: begin
          if (term_s) begin
            state_r <= ST_DONE;
            cause_r <= term_cause(core_stat, limit_hit_s);
          end else if (core_en_s) begin
            cycle_r <= cycle_r + CYC_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  trace_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (TRACE_DEPTH),
    .IDX_W  (IDX_W)
  ) u_trace (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (launch_s),
    .wr_en   (core_en_s),
    .wr_pc   (pc_in),
    .wr_data (watch_in),
    .rd_idx  (trace_rd_idx),
    .count   (trace_count),
    .rd_pc   (trace_rd_pc),
    .rd_data (trace_rd_data)
  );

  assign core_en     = core_en_s;
  assign state       = state_r;
  assign cycle_count = cycle_r;
  assign done_cause  = cause_r;

endmodule

// File: tb/tb_arch_run_ctrl.sv
// Directed bench for arch_run_ctrl: per-cycle comparison against a queue-based
// behavioural model, plus hand-computed literal checks from the test plan.
module tb_arch_run_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, step_mode, step_req, stop;
  logic [31:0] max_cycles;
  logic [2:0]  core_stat;
  logic [63:0] pc_in, watch_in;
  logic        core_en;
  logic [1:0]  state;
  logic [31:0] cycle_count;
  logic [2:0]  done_cause;
  logic [2:0]  trace_count;
  logic [1:0]  trace_rd_idx;
  logic [63:0] trace_rd_pc, trace_rd_data;

  arch_run_ctrl #(.ADDR_W(64), .DATA_W(64), .CYC_W(32), .TRACE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode),
    .step_req(step_req), .stop(stop), .max_cycles(max_cycles),
    .core_stat(core_stat), .pc_in(pc_in), .watch_in(watch_in),
    .core_en(core_en), .state(state), .cycle_count(cycle_count),
    .done_cause(done_cause), .trace_count(trace_count),
    .trace_rd_idx(trace_rd_idx), .trace_rd_pc(trace_rd_pc),
    .trace_rd_data(trace_rd_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int en_hi = 0;

  // Model: 0 idle, 1 run, 2 pause, 3 done; trace kept newest-first.
  int          m_state, m_cause;
  logic [31:0] m_cyc, m_max;
  logic [63:0] q_pc[$];
  logic [63:0] q_dat[$];
  logic [63:0] m_rd_pc, m_rd_dat;
  bit          m_rd_ok;
  bit          m_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_limit();
    return (m_max != 0) && (m_cyc == m_max);
  endfunction

  function automatic bit model_term();
    return (core_stat != 3'd1) || stop || model_limit();
  endfunction

  function automatic bit model_en();
    if (!rst_n || model_term()) return 1'b0;
    if (m_state == 1) return 1'b1;
    if (m_state == 2) return step_req;
    return 1'b0;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_state = 0; m_cause = 0; m_cyc = 0; m_max = 0;
      q_pc.delete(); q_dat.delete();
      m_rd_pc = 0; m_rd_dat = 0; m_rd_ok = 1;
      return;
    end
    if (trace_rd_idx < q_pc.size()) begin
      m_rd_pc = q_pc[trace_rd_idx]; m_rd_dat = q_dat[trace_rd_idx]; m_rd_ok = 1;
    end else begin
      m_rd_ok = 0;
    end
    if (m_state == 0 || m_state == 3) begin
      if (start) begin
        m_cyc = 0; m_cause = 0; m_max = max_cycles;
        q_pc.delete(); q_dat.delete();
        m_state = step_mode ? 2 : 1;
      end
    end else if (model_term()) begin
      m_state = 3;
      if (core_stat == 3'd2) m_cause = 1;
      else if (core_stat != 3'd1) m_cause = 2;
      else if (model_limit()) m_cause = 3;
      else m_cause = 4;
    end else if (m_en) begin
      m_cyc++;
      q_pc.push_front(pc_in); q_dat.push_front(watch_in);
      if (q_pc.size() > DEPTH) begin
        void'(q_pc.pop_back()); void'(q_dat.pop_back());
      end
    end
  endtask

  // One clock: compare outputs against the model before the edge, then advance the model.
  task automatic tick();
    #1;
    m_en = model_en();
    check("core_en", 64'(core_en), 64'(m_en));
    check("state", 64'(state), 64'(m_state));
    check("cycle_count", 64'(cycle_count), 64'(m_cyc));
    check("done_cause", 64'(done_cause), 64'(m_cause));
    check("trace_count", 64'(trace_count), 64'(q_pc.size()));
    if (m_rd_ok) begin
      check("trace_rd_pc", trace_rd_pc, m_rd_pc);
      check("trace_rd_data", trace_rd_data, m_rd_dat);
    end
    if (core_en) en_hi++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic run_until_done(input int budget);
    for (int i = 0; i < budget && state != 2'd3; i++) tick();
    check("reach_done", 64'(state), 64'd3);
  endtask

  task automatic launch(input bit smode, input logic [31:0] maxc);
    start = 1'b1; step_mode = smode; max_cycles = maxc;
    tick();
    start = 1'b0; step_mode = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step_req = 1'b0; stop = 1'b0;
    max_cycles = 32'd0; core_stat = 3'd1; pc_in = 64'd0; watch_in = 64'd0;
    trace_rd_idx = 2'd0;
    m_state = 0; m_cause = 0; m_cyc = 0; m_max = 0; m_rd_ok = 0; m_en = 0;
    @(negedge clk);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_state", 64'(state), 64'd0);
    check("rst_rd_pc", trace_rd_pc, 64'd0);

    // Free run with limit 10.
    en_hi = 0;
    launch(1'b0, 32'd10);
    for (int i = 0; i < 30 && state != 2'd3; i++) begin
      pc_in = 64'(200 + i); watch_in = 64'(i * 3);
      tick();
    end
    check("t1_done", 64'(state), 64'd3);
    check("t1_en_cycles", 64'(en_hi), 64'd10);
    check("t1_cycles", 64'(cycle_count), 64'd10);
    check("t1_cause", 64'(done_cause), 64'd3);

    // Single-step with three isolated pulses; start while paused is ignored.
    launch(1'b1, 32'd0);
    for (int p = 0; p < 3; p++) begin
      pc_in = 64'(500 + p); watch_in = 64'(p);
      start = (p == 1);
      tick(); tick();
      start = 1'b0;
      step_req = 1'b1; tick(); step_req = 1'b0;
    end
    tick();
    check("t2_state", 64'(state), 64'd2);
    check("t2_cycles", 64'(cycle_count), 64'd3);
    check("t2_trace", 64'(trace_count), 64'd3);
    stop = 1'b1; tick(); stop = 1'b0;
    check("t2_stop_cause", 64'(done_cause), 64'd4);

    // Halt and stop together at cycle 5: halt wins.
    launch(1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      pc_in = 64'(700 + i); tick();
    end
    core_stat = 3'd2; stop = 1'b1;
    #1 check("t3_en_low", 64'(core_en), 64'd0);
    tick();
    core_stat = 3'd1; stop = 1'b0;
    check("t3_state", 64'(state), 64'd3);
    check("t3_cycles", 64'(cycle_count), 64'd5);
    check("t3_cause", 64'(done_cause), 64'd1);

    // Trace wrap: PCs 0..90 over 10 cycles, read newest-first.
    launch(1'b0, 32'd10);
    for (int k = 0; k < 10; k++) begin
      pc_in = 64'(10 * k); watch_in = 64'(10 * k + 1); tick();
    end
    run_until_done(5);
    check("t4_trace", 64'(trace_count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      trace_rd_idx = 2'(i);
      tick();
      check("t4_rd_pc", trace_rd_pc, 64'(90 - 10 * i));
      check("t4_rd_data", trace_rd_data, 64'(91 - 10 * i));
    end

    // Reset mid-run at cycle 7.
    launch(1'b0, 32'd0);
    for (int i = 0; i < 7; i++) tick();
    check("t5_pre_cycles", 64'(cycle_count), 64'd7);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    #1;
    check("t5_state", 64'(state), 64'd0);
    check("t5_cycles", 64'(cycle_count), 64'd0);
    check("t5_en", 64'(core_en), 64'd0);
    check("t5_rd_pc", trace_rd_pc, 64'd0);
    tick();

    // Restart from DONE, fault after 4 cycles.
    launch(1'b0, 32'd3);
    run_until_done(10);
    launch(1'b0, 32'd0);
    check("t6_clr_cycles", 64'(cycle_count), 64'd0);
    check("t6_clr_trace", 64'(trace_count), 64'd0);
    for (int i = 0; i < 4; i++) begin
      pc_in = 64'(900 + i); tick();
    end
    core_stat = 3'd3; tick(); core_stat = 3'd1;
    check("t6_cause", 64'(done_cause), 64'd2);
    check("t6_cycles", 64'(cycle_count), 64'd4);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
